sid_bus_scheduler: RTL and testbench
====================================

# sid_bus_scheduler

Shares the single SID register-write bus between four independent requesters (sequencer, modulators, filter sweep, init logic) on the C6 board. Generates the 1 MHz SID_CLK from the 8 MHz board clock, holds the SID in reset after power-up, and turns round-robin-arbitrated write requests into correctly timed chip-select cycles on SID_ADDR/SID_DATA/SID_NOTCS. It replaces ad-hoc per-cycle address/data muxing with a request/acknowledge interface.

## Interface
- DIV_LOG2, 3: SID_CLK = C6_CLK_8MHZ / 2^DIV_LOG2.
- RESET_CYCLES, 16: SID cycles SID_NOTRES is held low after reset release. Minimum 10.
- C6_CLK_8MHZ  in  1  board clock; all logic on its rising edge.
- C6_NOTRES  in  1  asynchronous, active-low reset.
- REQ  in  4  per-requester write request. Level signal; port 0 is bit 0.
- REQ_ADDR  in  20  4 x 5-bit SID register address; port n is at [5n+4:5n].
- REQ_DATA  in  32  4 x 8-bit write data; port n is at [8n+7:8n].
- ACK  out  4  one-clock pulse when port n's request is consumed.
- BUSY  out  1  high while in RESET_HOLD, WRITE or GAP.
- SID_CLK  out  1  SID phi2.
- SID_NOTRES  out  1  SID reset, active low.
- SID_NOTCS  out  1  SID chip select, active low.
- SID_ADDR  out  5  register address.
- SID_DATA  out  8  write data.

## Operation
- Phase counter ph (DIV_LOG2 bits) free-runs.
  - SID_CLK = ph MSB: high for ph 4..7, low for ph 0..3.
  - A "slot edge" is the clock where ph wraps 7->0, i.e. the SID_CLK falling edge.
- All state changes happen only on slot edges, except ACK pulses and the shadow compare.
- States:
  - RESET_HOLD: SID_NOTRES=0. Counts RESET_CYCLES slot edges, then goes to IDLE with SID_NOTRES=1. REQ is ignored and no ACK is issued.
  - IDLE: on a slot edge with any REQ bit set, grant round-robin starting from the port after the last granted port (port 0 first after reset).
    - Register the granted port's addr/data onto SID_ADDR/SID_DATA, drive SID_NOTCS=0, pulse ACK[n] on that same clock, go to WRITE.
    - With no REQ set, stay in IDLE.
  - WRITE: lasts one full SID cycle. On the next slot edge: SID_NOTCS=1, go to GAP. SID latches on the SID_CLK falling edge with CS low.
  - GAP: one SID cycle with CS high and addr/data held. On the next slot edge, re-arbitrate exactly as in IDLE.
- Peak throughput is one write per 2 SID cycles. GAP may go directly to WRITE.
- Requester rules:
  - Hold REQ_ADDR/REQ_DATA stable while REQ is high.
  - After ACK, either drop REQ or present the next write on the following clock.
  - A request that drops before ACK is abandoned, with no bus effect.
- SID_ADDR/SID_DATA change only on slot edges that start WRITE. They are never changed while SID_NOTCS=0.
- Reset (C6_NOTRES low, at any time including mid-WRITE) sets outputs immediately:
  - ph=0, SID_CLK=0, SID_NOTRES=0, SID_NOTCS=1, SID_ADDR=0, SID_DATA=0, ACK=0, BUSY=1.
  - State goes to RESET_HOLD and the round-robin pointer is cleared.

## Timing
- Latency from REQ rising (in IDLE) to grant/ACK: 1..8 clocks, at the next slot edge.
- SID_NOTCS low for exactly 8 clocks, from slot edge to slot edge.
- Write launched to next possible grant: 16 clocks.
- With all four REQ held high, grants are 0,1,2,3,0… at 16-clock spacing.
- First possible grant is RESET_CYCLES x 8 clocks after C6_NOTRES rises, plus up to 8 clocks of phase alignment.

## Configuration
- SID_BUS_SHADOW_EN defined:
  - Adds a 25 x 8 shadow of SID registers 0x00..0x18, each with a valid bit; valid bits are cleared by reset.
  - At grant, if addr ≤ 0x18, the valid bit is set, and data equals the shadow entry, the write is suppressed: ACK[n] still pulses, state stays IDLE/GAP, no CS cycle occurs, and the pointer advances.
  - Otherwise the write proceeds normally, and the shadow entry is updated and marked valid.
  - Addresses 0x19..0x1F always pass through and are never shadowed.
- Not defined: every granted request produces a bus cycle, and no shadow storage is instantiated.

## Test plan
- Reset: release C6_NOTRES → SID_NOTRES low for 128 clocks; REQ[0]=1 during that window gets no ACK. The first ACK comes at the first slot edge after SID_NOTRES rises.
- Single write: REQ[2]=1, addr 0x18, data 0x1F → ACK[2] one clock, SID_NOTCS low 8 clocks across one SID_CLK falling edge, with SID_ADDR=0x18 and SID_DATA=0x1F stable throughout.
- Fairness: REQ=4'b1111 held for 8 writes → grant order 0,1,2,3,0,1,2,3, CS cycles 16 clocks apart, and exactly 2 ACKs per port.
- Mid-write reset: assert C6_NOTRES while SID_NOTCS=0 → same clock SID_NOTCS=1, SID_ADDR=0, SID_DATA=0, SID_CLK=0; RESET_HOLD re-entered.
- Abandoned request: REQ[1] pulses for 3 clocks between slot edges → no ACK, no CS cycle.
- Shadow (SID_BUS_SHADOW_EN): write 0x04←0x11 twice then 0x04←0x10 → 3 ACKs but only 2 CS cycles. A write of 0x1B←0x00 twice → 2 CS cycles.

Source files
------------

// File: rtl/sid_bus_scheduler.sv
// sid_bus_scheduler: shares the SID register-write bus between four requesters.
// Divides C6_CLK_8MHZ into SID_CLK, holds SID_NOTRES low after reset, and
// turns round-robin granted REQ/REQ_ADDR/REQ_DATA into SID_NOTCS write cycles.
// Ports: C6_CLK_8MHZ, C6_NOTRES (async, active low); REQ[3:0], REQ_ADDR[19:0],
//   REQ_DATA[31:0] in; ACK[3:0], BUSY, SID_CLK, SID_NOTRES, SID_NOTCS,
//   SID_ADDR[4:0], SID_DATA[7:0] out.
// Build option: define SID_BUS_SHADOW_EN to skip writes of unchanged values
//   to registers 0x00..0x18.
module sid_bus_scheduler #(
    parameter int DIV_LOG2     = 3,
    parameter int RESET_CYCLES = 16
) (
    input  logic        C6_CLK_8MHZ,
    input  logic        C6_NOTRES,
    input  logic [3:0]  REQ,
    input  logic [19:0] REQ_ADDR,
    input  logic [31:0] REQ_DATA,
    output logic [3:0]  ACK,
    output logic        BUSY,
    output logic        SID_CLK,
    output logic        SID_NOTRES,
    output logic        SID_NOTCS,
    output logic [4:0]  SID_ADDR,
    output logic [7:0]  SID_DATA
);

    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_HOLD,
        IDLE,
        WRITE,
        GAP
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [DIV_LOG2-1:0] ph;
    logic [CW-1:0]       rst_cnt;
    logic [1:0]          rr;
    logic [1:0]          gnt_idx;
    logic [1:0]          cand;
    logic                gnt_any;
    logic                slot;
    logic                grant;
    logic                launch;
    logic                hit;
    logic [4:0]          sel_addr;
    logic [7:0]          sel_data;

    // Slot edge: the clock on which ph wraps, i.e. SID_CLK falls.
    assign slot       = &ph;
    assign SID_CLK    = ph[DIV_LOG2-1];
    assign SID_NOTRES = (state != RESET_HOLD);
    assign BUSY       = (state != IDLE);

    // Round robin: scan from rr downwards in priority so the port
    // nearest to rr is the last one to overwrite the choice.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr;
        cand    = rr;
        for (int i = 3; i >= 0; i--) begin
            cand = rr + 2'(i);
            if (REQ[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        sel_addr = REQ_ADDR[5*int'(gnt_idx) +: 5];
        sel_data = REQ_DATA[8*int'(gnt_idx) +: 8];
    end

`ifdef SID_BUS_SHADOW_EN
    logic [7:0]  shadow [25];
    logic [24:0] shadow_vld;
    logic        in_range;

    assign in_range = (sel_addr <= 5'd24);
    assign hit      = in_range && shadow_vld[sel_addr]
                      && (shadow[sel_addr] == sel_data);

    always_ff @(posedge C6_CLK_8MHZ or negedge C6_NOTRES) begin
        if (!C6_NOTRES) begin
            shadow_vld <= '0;
        end else if (launch && in_range) begin
            shadow_vld[sel_addr] <= 1'b1;
        end
    end

    // Contents are meaningless until the valid bit is set.
    always_ff @(posedge C6_CLK_8MHZ) begin
        if (launch && in_range) begin
            shadow[sel_addr] <= sel_data;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        launch  = 1'b0;
        unique case (state)
            RESET_HOLD: begin
                if (slot && rst_cnt == RST_LAST) state_n = IDLE;
            end
            IDLE, GAP: begin
                if (slot && gnt_any) begin
                    grant = 1'b1;
                    // A suppressed write is acknowledged but leaves
                    // the state untouched.
                    if (!hit) begin
                        launch  = 1'b1;
                        state_n = WRITE;
                    end
                end else if (slot) begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
                if (slot) state_n = GAP;
            end
            default: state_n = RESET_HOLD;
        endcase
    end

    always_ff @(posedge C6_CLK_8MHZ or negedge C6_NOTRES) begin
        if (!C6_NOTRES) begin
            state <= RESET_HOLD;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge C6_CLK_8MHZ or negedge C6_NOTRES) begin
        if (!C6_NOTRES) begin
            ph        <= '0;
            rst_cnt   <= '0;
            rr        <= '0;
            ACK       <= '0;
            SID_NOTCS <= 1'b1;
            SID_ADDR  <= '0;
            SID_DATA  <= '0;
        end else begin
            ph  <= ph + DIV_LOG2'(1);
            ACK <= grant ? (4'b0001 << gnt_idx) : 4'b0000;
            if (state == RESET_HOLD && slot) rst_cnt <= rst_cnt + CW'(1);
            if (grant) rr <= gnt_idx + 2'd1;
            if (slot) SID_NOTCS <= !launch;
            if (launch) begin
                SID_ADDR <= sel_addr;
                SID_DATA <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_sid_bus_scheduler.sv
// tb_sid_bus_scheduler: directed and random checks of sid_bus_scheduler
// against a timestamp-based reference model.
module tb_sid_bus_scheduler;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [3:0]  req      = '0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        busy;
    logic        sid_clk;
    logic        sid_notres;
    logic        sid_notcs;
    logic [4:0]  sid_addr;
    logic [7:0]  sid_data;

    sid_bus_scheduler dut (
        .C6_CLK_8MHZ (clk),
        .C6_NOTRES   (rst_n),
        .REQ         (req),
        .REQ_ADDR    (req_addr),
        .REQ_DATA    (req_data),
        .ACK         (ack),
        .BUSY        (busy),
        .SID_CLK     (sid_clk),
        .SID_NOTRES  (sid_notres),
        .SID_NOTCS   (sid_notcs),
        .SID_ADDR    (sid_addr),
        .SID_DATA    (sid_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: n counts rising edges since reset release.
    int          n;
    int          busy_until;
    int          launch_t;
    int          rr_m;
    logic [3:0]  e_ack;
    logic [4:0]  e_addr;
    logic [7:0]  e_data;
    logic [7:0]  m_sh [25];
    logic [24:0] m_sv;

    // Observations
    int   cs_low   = 0;
    int   cs_falls = 0;
    logic prev_cs  = 1'b1;
    int   ack_cnt [4];
    int   ack_q [$];
    int   ack_tq [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h n=%0d",
                   tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n          = 0;
        busy_until = 0;
        launch_t   = -100;
        rr_m       = 0;
        e_ack      = '0;
        e_addr     = '0;
        e_data     = '0;
        m_sv       = '0;
    endtask

    // Slot edges are every 8th edge; the first grant chance is the slot
    // after the 16-slot reset hold; a launch owns the bus for 16 clocks.
    task automatic model_step();
        int         g;
        int         p;
        logic [4:0] a;
        logic [7:0] d;
        logic       sup;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n++;
        e_ack = '0;
        if (n % 8 == 0 && n >= 136 && n >= busy_until) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
                p = (rr_m + k) % 4;
                if (g < 0 && req[p]) g = p;
            end
            if (g >= 0) begin
                a        = req_addr[5*g +: 5];
                d        = req_data[8*g +: 8];
                e_ack[g] = 1'b1;
                rr_m     = (g + 1) % 4;
                sup      = 1'b0;
`ifdef SID_BUS_SHADOW_EN
                sup = (a <= 24) && m_sv[a] && (m_sh[a] == d);
`endif
                if (!sup) begin
                    launch_t   = n;
                    busy_until = n + 16;
                    e_addr     = a;
                    e_data     = d;
                    if (a <= 24) begin
                        m_sh[a] = d;
                        m_sv[a] = 1'b1;
                    end
                end else if (n == busy_until) begin
                    busy_until = n + 8;
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        check("ack", 32'(ack), 32'(e_ack));
        check("notcs", 32'(sid_notcs),
              32'(!(n >= launch_t && n < launch_t + 8)));
        check("addr", 32'(sid_addr), 32'(e_addr));
        check("data", 32'(sid_data), 32'(e_data));
        check("sid_clk", 32'(sid_clk), 32'((n % 8) >= 4));
        check("notres", 32'(sid_notres), 32'(n >= 128));
        check("busy", 32'(busy), 32'(n < 128 || n < busy_until));
        if (sid_notcs === 1'b0) cs_low++;
        if (prev_cs === 1'b1 && sid_notcs === 1'b0) cs_falls++;
        prev_cs = sid_notcs;
        for (int p = 0; p < 4; p++) begin
            if (ack[p] === 1'b1) begin
                ack_cnt[p]++;
                ack_q.push_back(p);
                ack_tq.push_back(n);
            end
        end
    endtask

    task automatic clear_acks();
        for (int p = 0; p < 4; p++) ack_cnt[p] = 0;
        ack_q.delete();
        ack_tq.delete();
    endtask

    task automatic do_write(input int p, input logic [4:0] a,
                            input logic [7:0] d);
        req_addr[5*p +: 5] = a;
        req_data[8*p +: 8] = d;
        req[p] = 1'b1;
        for (int w = 0; w < 64; w++) begin
            cyc();
            if (e_ack[p]) break;
        end
        check("wr_ack", 32'(ack[p]), 32'd1);
        req[p] = 1'b0;
    endtask

    task automatic new_req(input int p);
        req_addr[5*p +: 5] = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 0)
            req_data[8*p +: 8] = 8'($urandom_range(0, 3));
        else
            req_data[8*p +: 8] = 8'($urandom_range(0, 255));
        req[p] = 1'b1;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int first_ack;
        int base_cs;
        int base_ack;

        model_reset();
        clear_acks();

        // Reset state
        repeat (3) cyc();

        // Power-up: REQ[0] held through the reset window
        req_addr[4:0] = 5'h01;
        req_data[7:0] = 8'h5A;
        req[0]        = 1'b1;
        rst_n         = 1'b1;
        first_ack     = -1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (ack[0] === 1'b1) begin
                first_ack = n;
                break;
            end
        end
        check("first_ack_n", 32'(first_ack), 32'd136);
        req[0] = 1'b0;
        repeat (20) cyc();

        // Single write on port 2
        clear_acks();
        cs_low = 0;
        do_write(2, 5'h18, 8'h1F);
        repeat (20) cyc();
        check("single_cs_low", 32'(cs_low), 32'd8);
        check("single_ack2", 32'(ack_cnt[2]), 32'd1);

        // Abandoned request between slot edges
        for (int i = 0; i < 8; i++) begin
            if (n % 8 == 0) break;
            cyc();
        end
        base_cs  = cs_falls;
        base_ack = ack_cnt[1];
        req_addr[9:5]  = 5'h07;
        req_data[15:8] = 8'h33;
        req[1] = 1'b1;
        repeat (3) cyc();
        req[1] = 1'b0;
        repeat (24) cyc();
        check("abandon_cs", 32'(cs_falls), 32'(base_cs));
        check("abandon_ack", 32'(ack_cnt[1]), 32'(base_ack));

        // Reset in the middle of a write, with SID_CLK high
        do_write(1, 5'h05, 8'hA5);
        repeat (4) cyc();
        rst_n = 1'b0;
        #1;
        check("mrst_notcs", 32'(sid_notcs), 32'd1);
        check("mrst_addr", 32'(sid_addr), 32'd0);
        check("mrst_data", 32'(sid_data), 32'd0);
        check("mrst_clk", 32'(sid_clk), 32'd0);
        check("mrst_notres", 32'(sid_notres), 32'd0);
        check("mrst_busy", 32'(busy), 32'd1);
        check("mrst_ack", 32'(ack), 32'd0);
        repeat (2) cyc();

        // Fairness with all four ports requesting
        for (int p = 0; p < 4; p++) begin
            req_addr[5*p +: 5] = 5'(5'h10 + p);
            req_data[8*p +: 8] = 8'(8'h40 + p);
        end
        req = 4'b1111;
        clear_acks();
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (ack_q.size() >= 8) break;
        end
        req = 4'b0000;
        check("fair_count", 32'(ack_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < ack_q.size()) check("fair_order", 32'(ack_q[i]), 32'(i % 4));
            if (i > 0 && i < ack_tq.size())
                check("fair_space", 32'(ack_tq[i] - ack_tq[i-1]), 32'd16);
        end
        for (int p = 0; p < 4; p++)
            check("fair_per_port", 32'(ack_cnt[p]), 32'd2);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            cyc();
            for (int p = 0; p < 4; p++) begin
                if (req[p]) begin
                    if (e_ack[p]) begin
                        if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
                        else new_req(p);
                    end else if ($urandom_range(0, 63) == 0) begin
                        req[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    new_req(p);
                end
            end
        end
        req = 4'b0000;
        repeat (24) cyc();

`ifdef SID_BUS_SHADOW_EN
        // Shadowed register: repeated identical value is suppressed
        hold_reset();
        repeat (130) cyc();
        clear_acks();
        base_cs = cs_falls;
        do_write(0, 5'h04, 8'h11);
        repeat (20) cyc();
        do_write(0, 5'h04, 8'h11);
        repeat (20) cyc();
        do_write(0, 5'h04, 8'h10);
        repeat (20) cyc();
        check("shadow_acks", 32'(ack_cnt[0]), 32'd3);
        check("shadow_cs", 32'(cs_falls - base_cs), 32'd2);
        base_cs = cs_falls;
        do_write(0, 5'h1B, 8'h00);
        repeat (20) cyc();
        do_write(0, 5'h1B, 8'h00);
        repeat (20) cyc();
        check("unshadowed_cs", 32'(cs_falls - base_cs), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
